// File: rtl/blk_ocp_client_pkg.sv
// Shared definitions for the block OCP client: request FSM encoding and
// the default block address width used by the memory manager.
package blk_ocp_client_pkg;

  localparam int DEF_AWIDTH = 10;

  // Request FSM: IDLE has no request outstanding, WAIT holds ocp_req high
  // until the manager's grant strobe arrives.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } req_state_t;

endpackage

// File: rtl/blk_addr_fifo.sv
// First-word-fall-through FIFO of block addresses with an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
// Pushes while full and pops while empty are ignored.
module blk_addr_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             wr_en;
  logic             rd_en;

  // Qualify the requests against the current occupancy.
  always_comb begin
    wr_en = push && (cnt != FULL_CNT);
    rd_en = pop && (cnt != '0);
  end

  // Pointers and count; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Head entry falls through to the output.
  always_comb begin
    head  = mem[rd_ptr];
    count = cnt;
  end

endmodule

// File: rtl/blk_ocp_client.sv
// Block OCP client: prefetches free blocks from the memory manager one grant
// at a time into a FWFT FIFO for the write path, and queues returned blocks
// from the read path, releasing one per cycle back to the manager.
// Optional statistics counters are built when BLK_CLIENT_STAT_EN is defined.
//
// Handshakes: alloc_* and rel_* transfer a word on every rising edge where
// the valid and ready of that pair are both 1; valid is never conditioned
// on ready. ocp_vld and rls_vld are one-cycle strobes with no backpressure.
module blk_ocp_client
  import blk_ocp_client_pkg::*;
#(
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int PF_DEPTH = 4,
  parameter int RQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      ocp_req,
  input  logic                      ocp_vld,
  input  logic [AWIDTH-1:0]         ocp_block_addr,
  input  logic                      mgr_full,
  output logic                      rls_vld,
  output logic [AWIDTH-1:0]         rls_block_addr,
  output logic                      alloc_vld,
  input  logic                      alloc_rdy,
  output logic [AWIDTH-1:0]         alloc_addr,
  input  logic                      rel_vld,
  output logic                      rel_rdy,
  input  logic [AWIDTH-1:0]         rel_addr,
  output logic [$clog2(PF_DEPTH):0] pf_count,
`ifdef BLK_CLIENT_STAT_EN
  output logic [31:0]               stat_grant_cnt,
  output logic [31:0]               stat_rls_cnt,
`endif
  output req_state_t                dbg_state
);

  localparam int PF_CW = $clog2(PF_DEPTH) + 1;
  localparam int RQ_CW = $clog2(RQ_DEPTH) + 1;
  localparam logic [PF_CW-1:0] PF_FULL = PF_CW'(PF_DEPTH);
  localparam logic [RQ_CW-1:0] RQ_FULL = RQ_CW'(RQ_DEPTH);

  req_state_t        state;
  req_state_t        state_nxt;
  logic              pf_push;
  logic              pf_pop;
  logic [PF_CW-1:0]  pf_cnt;
  logic [AWIDTH-1:0] pf_head;
  logic              rq_push;
  logic              rq_pop;
  logic [RQ_CW-1:0]  rq_cnt;
  logic [AWIDTH-1:0] rq_head;

  // Handshake qualification for both FIFOs.
  always_comb begin
    pf_push   = ocp_vld && (pf_cnt != PF_FULL);
    alloc_vld = (pf_cnt != '0);
    pf_pop    = alloc_vld && alloc_rdy;
    rel_rdy   = (rq_cnt != RQ_FULL);
    rq_push   = rel_vld && rel_rdy;
    rq_pop    = (rq_cnt != '0);
  end

  blk_addr_fifo #(
    .WIDTH (AWIDTH),
    .DEPTH (PF_DEPTH)
  ) u_pf_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pf_push),
    .push_data (ocp_block_addr),
    .pop       (pf_pop),
    .head      (pf_head),
    .count     (pf_cnt)
  );

  blk_addr_fifo #(
    .WIDTH (AWIDTH),
    .DEPTH (RQ_DEPTH)
  ) u_rq_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rq_push),
    .push_data (rel_addr),
    .pop       (rq_pop),
    .head      (rq_head),
    .count     (rq_cnt)
  );

  // Request FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state. Grants only arrive in WAIT, so from IDLE there are no
  // pending pushes and the occupancy alone decides whether room remains.
  // mgr_full is only looked at before requesting; once in WAIT the request
  // is held until the grant.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!mgr_full && (pf_cnt < PF_FULL)) state_nxt = WAIT;
      WAIT: if (ocp_vld) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded straight from the state flop, so ocp_req is glitch-free.
  always_comb begin
    ocp_req    = (state == WAIT);
    dbg_state  = state;
    alloc_addr = pf_head;
    pf_count   = pf_cnt;
  end

  // Release drain: one entry per cycle, strobed to the manager a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rls_vld        <= 1'b0;
      rls_block_addr <= '0;
    end else begin
      rls_vld <= rq_pop;
      if (rq_pop) rls_block_addr <= rq_head;
    end
  end

`ifdef BLK_CLIENT_STAT_EN
  // Free-running grant and release pulse counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant_cnt <= '0;
      stat_rls_cnt   <= '0;
    end else begin
      if (ocp_vld) stat_grant_cnt <= stat_grant_cnt + 32'd1;
      if (rls_vld) stat_rls_cnt   <= stat_rls_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_blk_ocp_client.sv
// Bench for blk_ocp_client: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_blk_ocp_client;
  import blk_ocp_client_pkg::*;

  localparam int AW  = 10;
  localparam int PFD = 4;
  localparam int RQD = 4;
  localparam int PCW = $clog2(PFD) + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic           ocp_req;
  logic           ocp_vld = 1'b0;
  logic [AW-1:0]  ocp_block_addr = '0;
  logic           mgr_full = 1'b0;
  logic           rls_vld;
  logic [AW-1:0]  rls_block_addr;
  logic           alloc_vld;
  logic           alloc_rdy = 1'b0;
  logic [AW-1:0]  alloc_addr;
  logic           rel_vld = 1'b0;
  logic           rel_rdy;
  logic [AW-1:0]  rel_addr = '0;
  logic [PCW-1:0] pf_count;
  req_state_t     dbg_state;
`ifdef BLK_CLIENT_STAT_EN
  logic [31:0]    stat_grant_cnt;
  logic [31:0]    stat_rls_cnt;
`endif

  blk_ocp_client #(
    .AWIDTH   (AW),
    .PF_DEPTH (PFD),
    .RQ_DEPTH (RQD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ocp_req        (ocp_req),
    .ocp_vld        (ocp_vld),
    .ocp_block_addr (ocp_block_addr),
    .mgr_full       (mgr_full),
    .rls_vld        (rls_vld),
    .rls_block_addr (rls_block_addr),
    .alloc_vld      (alloc_vld),
    .alloc_rdy      (alloc_rdy),
    .alloc_addr     (alloc_addr),
    .rel_vld        (rel_vld),
    .rel_rdy        (rel_rdy),
    .rel_addr       (rel_addr),
    .pf_count       (pf_count),
`ifdef BLK_CLIENT_STAT_EN
    .stat_grant_cnt (stat_grant_cnt),
    .stat_rls_cnt   (stat_rls_cnt),
`endif
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- manager model (stimulus) ----------------
  // Grants one block per request after a random latency; addresses run
  // mgr_base, mgr_base+1, ... and stop after mgr_limit grants since reset.
  int mgr_base    = 5;
  int mgr_limit   = 0;
  int mgr_lat_max = 0;
  int mgr_cnt     = 0;
  int mgr_wait    = 0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      ocp_vld  = 1'b0;
      mgr_cnt  = 0;
      mgr_wait = $urandom_range(mgr_lat_max, 0);
    end else if (ocp_req && !ocp_vld && !mgr_full && (mgr_cnt < mgr_limit)) begin
      if (mgr_wait == 0) begin
        ocp_vld        = 1'b1;
        ocp_block_addr = AW'(mgr_base + mgr_cnt);
        mgr_cnt++;
        mgr_wait = $urandom_range(mgr_lat_max, 0);
      end else begin
        ocp_vld = 1'b0;
        mgr_wait--;
      end
    end else begin
      ocp_vld = 1'b0;
    end
  end

  // ---------------- behavioural reference model ----------------
  // Prefetch and release FIFOs as plain queues; the request is raised when
  // there is room and the manager is not full, dropped by a grant.
  logic [AW-1:0] pf_q[$];
  logic [AW-1:0] rq_q[$];
  logic          m_req      = 1'b0;
  logic          m_rls_vld  = 1'b0;
  logic [AW-1:0] m_rls_addr = '0;
  int            pf_n;
  int            rq_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_q.delete();
      rq_q.delete();
      m_req      = 1'b0;
      m_rls_vld  = 1'b0;
      m_rls_addr = '0;
    end else begin
      pf_n = pf_q.size();
      rq_n = rq_q.size();
      // release side: drain the oldest entry, accept a new one if room
      if (rq_n != 0) begin
        m_rls_vld  = 1'b1;
        m_rls_addr = rq_q.pop_front();
      end else begin
        m_rls_vld = 1'b0;
      end
      if (rel_vld && (rq_n < RQD)) rq_q.push_back(rel_addr);
      // prefetch side
      if (alloc_rdy && (pf_n != 0)) void'(pf_q.pop_front());
      if (ocp_vld) pf_q.push_back(ocp_block_addr);
      // request level
      if (!m_req) m_req = (pf_n < PFD) && !mgr_full;
      else if (ocp_vld) m_req = 1'b0;
    end
  end

  // One compare process: every cycle out of reset, DUT against model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ocp_req", 32'(ocp_req), 32'(m_req));
      chk("pf_count", 32'(pf_count), 32'(pf_q.size()));
      chk("alloc_vld", 32'(alloc_vld), 32'(pf_q.size() != 0));
      if (pf_q.size() != 0) chk("alloc_addr", 32'(alloc_addr), 32'(pf_q[0]));
      chk("rel_rdy", 32'(rel_rdy), 32'(rq_q.size() < RQD));
      chk("rls_vld", 32'(rls_vld), 32'(m_rls_vld));
      if (m_rls_vld) chk("rls_addr", 32'(rls_block_addr), 32'(m_rls_addr));
    end
  end

  // Release log for the literal checks of the directed scenarios.
  logic [AW-1:0] rls_seen[$];
  int            rls_cyc[$];
  always @(negedge clk) begin
    if (rst_n && rls_vld) begin
      rls_seen.push_back(rls_block_addr);
      rls_cyc.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    alloc_rdy = 1'b0;
    rel_vld   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_pf(input int n, input string name);
    int k;
    k = 0;
    while ((pf_count !== PCW'(n)) && (k < 200)) begin
      tick();
      k++;
    end
    chk(name, 32'(pf_count), 32'(n));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ocp_req"}, 32'(ocp_req), 32'd0);
    chk({tag, "_rls_vld"}, 32'(rls_vld), 32'd0);
    chk({tag, "_rls_addr"}, 32'(rls_block_addr), 32'd0);
    chk({tag, "_alloc_vld"}, 32'(alloc_vld), 32'd0);
    chk({tag, "_pf_count"}, 32'(pf_count), 32'd0);
    chk({tag, "_rel_rdy"}, 32'(rel_rdy), 32'd1);
  endtask

  // Watchdog: the run must always reach its summary.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  int base;
  int idx;
  int k;
  logic hs;
  int rdy_pct;

  initial begin
    // Reset values, then grants 5..8 with alloc_rdy held low.
    mgr_full    = 1'b0;
    mgr_base    = 5;
    mgr_limit   = 5;
    mgr_lat_max = 2;
    rst_n       = 1'b0;
    repeat (2) tick();
    chk_reset_vals("rst0");
    do_reset();
    wait_pf(4, "a_fill");
    repeat (5) tick();
    @(negedge clk);
    chk("a_req_low", 32'(ocp_req), 32'd0);
    chk("a_count", 32'(pf_count), 32'd4);
    chk("a_head", 32'(alloc_addr), 32'd5);
    chk("a_vld", 32'(alloc_vld), 32'd1);

    // One pop from the full FIFO; the next grant (9) lands behind 8.
    tick();
    alloc_rdy = 1'b1;
    tick();
    alloc_rdy = 1'b0;
    wait_pf(4, "b_refill");
    @(negedge clk);
    alloc_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b_order", 32'(alloc_addr), 32'(6 + i));
      @(negedge clk);
    end
    chk("b_empty", 32'(alloc_vld), 32'd0);
    alloc_rdy = 1'b0;
    tick();

    // Manager full from reset: no request until it clears.
    mgr_full  = 1'b1;
    mgr_base  = 20;
    mgr_limit = 4;
    do_reset();
    repeat (10) begin
      @(negedge clk);
      chk("c_no_req", 32'(ocp_req), 32'd0);
      chk("c_no_alloc", 32'(alloc_vld), 32'd0);
    end
    tick();
    mgr_full = 1'b0;
    @(negedge clk);
    chk("c_req_same_cycle", 32'(ocp_req), 32'd0);
    @(negedge clk);
    chk("c_req_next_cycle", 32'(ocp_req), 32'd1);

    // Three releases on consecutive cycles.
    tick();
    base = rls_seen.size();
    rel_vld  = 1'b1;
    rel_addr = 10'd3;
    tick();
    rel_addr = 10'd4;
    tick();
    rel_addr = 10'd5;
    tick();
    rel_vld = 1'b0;
    repeat (4) tick();
    chk("d_rls_count", 32'(rls_seen.size() - base), 32'd3);
    if (rls_seen.size() >= base + 3) begin
      for (int i = 0; i < 3; i++) chk("d_rls_addr", 32'(rls_seen[base + i]), 32'(3 + i));
      chk("d_rls_back2back", 32'(rls_cyc[base + 2] - rls_cyc[base]), 32'd2);
    end

    // rel_vld held across six transfers; none lost, order kept.
    base     = rls_seen.size();
    rel_vld  = 1'b1;
    rel_addr = 10'd10;
    idx      = 0;
    k        = 0;
    while ((idx < 6) && (k < 60)) begin
      @(negedge clk);
      hs = rel_rdy;
      tick();
      k++;
      if (hs) begin
        idx++;
        rel_addr = AW'(10 + idx);
      end
    end
    rel_vld = 1'b0;
    repeat (6) tick();
    chk("e_rls_count", 32'(rls_seen.size() - base), 32'd6);
    if (rls_seen.size() >= base + 6)
      for (int i = 0; i < 6; i++) chk("e_rls_addr", 32'(rls_seen[base + i]), 32'(10 + i));

    // Reset in WAIT with two prefetched blocks and a release on the bus.
    mgr_base  = 40;
    mgr_limit = 2;
    do_reset();
    rel_vld  = 1'b1;
    rel_addr = 10'd7;
    tick();
    rel_vld = 1'b0;
    wait_pf(2, "f_fill");
    k = 0;
    while (!ocp_req && (k < 20)) begin
      tick();
      k++;
    end
    chk("f_in_wait", 32'(ocp_req), 32'd1);
    chk("f_last_rls", 32'(rls_block_addr), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("f_mid");
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("f_post");

    // Randomized traffic against the model.
    mgr_base    = 100;
    mgr_limit   = 1_000_000;
    mgr_lat_max = 3;
    do_reset();
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 200) == 0) rdy_pct = $urandom_range(100, 0);
      alloc_rdy = ($urandom_range(99, 0) < rdy_pct);
      rel_vld   = ($urandom_range(99, 0) < 60);
      rel_addr  = AW'($urandom);
      mgr_full  = ($urandom_range(9, 0) == 0);
      tick();
    end
    alloc_rdy = 1'b0;
    rel_vld   = 1'b0;
    mgr_full  = 1'b0;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
